game_controller: RTL and testbench

// - Game-flow sequencer downstream of hit_detection: consumes HitPulse and all_monsters_dead.
// - Runs the start / play / death / level-up / game-over FSM and keeps score (BCD), lives and level.
// - Drives level_reset and freeze into player/monsters, and score/lives/level to the HUD/background.

---
 rtl/game_controller.sv | 181 ++++++++++++++++++
 tb/tb_game_controller.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Game-flow sequencer: IDLE/PLAY/DYING/LEVEL_DONE/GAME_OVER with BCD score, lives and level.
// Define HIGH_SCORE_EN to add high_score_bcd, captured on entry to GAME_OVER.
module game_controller #(
   parameter int                       KEYCODE_WIDTH      = 9,
   parameter logic [KEYCODE_WIDTH-1:0] START_KEY          = 'h029,
   parameter int                       START_LIVES        = 3,
   parameter int                       MAX_LEVEL          = 9,
   parameter int                       DEATH_PAUSE_FRAMES = 90,
   parameter int                       LEVEL_PAUSE_FRAMES = 60
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     startOfFrame,
   input  logic [KEYCODE_WIDTH-1:0] keyCode,
   input  logic                     make,
   input  logic [4:0]               HitPulse,
   input  logic                     all_monsters_dead,
   output logic                     level_reset,
   output logic                     freeze,
   output logic                     game_active,
   output logic                     game_over,
   output logic [15:0]              score_bcd,
   output logic [2:0]               lives,
`ifdef HIGH_SCORE_EN
   output logic [15:0]              high_score_bcd,
`endif
   output logic [3:0]               level
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PLAY,
      S_DYING,
      S_LEVEL_DONE,
      S_GAME_OVER
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] score_q, score_d;
   logic [2:0]  lives_q, lives_d;
   logic [3:0]  level_q, level_d;
   logic [7:0]  frame_cnt_q, frame_cnt_d;
   logic        level_reset_q, level_reset_d;
   logic        freeze_q, freeze_d;
   logic        game_active_q, game_active_d;
   logic        game_over_q, game_over_d;
   logic        start_req;
   logic [1:0]  score_inc;
   logic [3:0]  level_next;
   logic        unused_border_hit;
`ifdef HIGH_SCORE_EN
   logic [15:0] high_score_q, high_score_d;
`endif

   // Border hits carry no game meaning here.
   assign unused_border_hit = HitPulse[3];

   // Per-digit BCD ripple add; a carry out of the thousands digit pins the score at 9999.
   function automatic logic [15:0] bcd_add(input logic [15:0] val, input logic [1:0] inc);
      logic [15:0] sum;
      logic [4:0]  digit;
      logic [1:0]  carry;
      sum   = '0;
      carry = inc;
      for (int i = 0; i < 4; i++) begin
         digit = {1'b0, val[4*i +: 4]} + {3'b000, carry};
         if (digit > 5'd9) begin
            sum[4*i +: 4] = 4'(digit - 5'd10);
            carry         = 2'd1;
         end else begin
            sum[4*i +: 4] = digit[3:0];
            carry         = 2'd0;
         end
      end
      return (carry != 2'd0) ? 16'h9999 : sum;
   endfunction

   always_comb begin
      start_req  = make && (keyCode == START_KEY);
      score_inc  = {1'b0, HitPulse[0]} + {1'b0, HitPulse[4]};
      level_next = (level_q >= 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : level_q + 4'd1;

      state_d     = state_q;
      score_d     = score_q;
      lives_d     = lives_q;
      level_d     = level_q;
      frame_cnt_d = startOfFrame ? frame_cnt_q + 8'd1 : frame_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start_req) begin
               state_d = S_PLAY;
               score_d = '0;
               lives_d = 3'(START_LIVES);
               level_d = 4'd1;
            end
         end
         S_PLAY: begin
            score_d = bcd_add(score_q, score_inc);
            if (HitPulse[2]) begin
               state_d = S_GAME_OVER;
            end else if (HitPulse[1] && lives_q == 3'd1) begin
               lives_d = 3'd0;
               state_d = S_GAME_OVER;
            end else if (HitPulse[1]) begin
               lives_d = lives_q - 3'd1;
               state_d = S_DYING;
            end else if (all_monsters_dead) begin
               level_d = level_next;
               state_d = S_LEVEL_DONE;
            end
         end
         S_DYING: begin
            if (startOfFrame && frame_cnt_q == 8'(DEATH_PAUSE_FRAMES - 1)) state_d = S_PLAY;
         end
         S_LEVEL_DONE: begin
            if (startOfFrame && frame_cnt_q == 8'(LEVEL_PAUSE_FRAMES - 1)) state_d = S_PLAY;
         end
         S_GAME_OVER: begin
            if (start_req) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q) frame_cnt_d = '0;

      // Outputs are decoded from the next state so the registered copies line up with state_q.
      level_reset_d = (state_d == S_IDLE) || (state_d == S_LEVEL_DONE);
      freeze_d      = (state_d != S_PLAY);
      game_active_d = (state_d == S_PLAY);
      game_over_d   = (state_d == S_GAME_OVER);

`ifdef HIGH_SCORE_EN
      high_score_d = high_score_q;
      if (state_q != S_GAME_OVER && state_d == S_GAME_OVER && score_d > high_score_q)
         high_score_d = score_d;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         score_q       <= '0;
         lives_q       <= 3'(START_LIVES);
         level_q       <= 4'd1;
         frame_cnt_q   <= '0;
         level_reset_q <= 1'b1;
         freeze_q      <= 1'b1;
         game_active_q <= 1'b0;
         game_over_q   <= 1'b0;
`ifdef HIGH_SCORE_EN
         high_score_q  <= '0;
`endif
      end else begin
         state_q       <= state_d;
         score_q       <= score_d;
         lives_q       <= lives_d;
         level_q       <= level_d;
         frame_cnt_q   <= frame_cnt_d;
         level_reset_q <= level_reset_d;
         freeze_q      <= freeze_d;
         game_active_q <= game_active_d;
         game_over_q   <= game_over_d;
`ifdef HIGH_SCORE_EN
         high_score_q  <= high_score_d;
`endif
      end
   end

   assign level_reset = level_reset_q;
   assign freeze      = freeze_q;
   assign game_active = game_active_q;
   assign game_over   = game_over_q;
   assign score_bcd   = score_q;
   assign lives       = lives_q;
   assign level       = level_q;
`ifdef HIGH_SCORE_EN
   assign high_score_bcd = high_score_q;
`endif

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed game scenarios plus random traffic, all checked every
// cycle against a decimal/string-state model of the game rules.
module tb_game_controller;

   localparam logic [8:0] START_KEY = 9'h029;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        startOfFrame = 1'b0;
   logic [8:0]  keyCode = '0;
   logic        make = 1'b0;
   logic [4:0]  HitPulse = '0;
   logic        all_monsters_dead = 1'b0;
   logic        level_reset, freeze, game_active, game_over;
   logic [15:0] score_bcd;
   logic [2:0]  lives;
   logic [3:0]  level;
`ifdef HIGH_SCORE_EN
   logic [15:0] high_score_bcd;
`endif

   int    checks   = 0;
   int    failures = 0;
   bit    check_en = 1'b0;

   string m_state = "IDLE";
   string m_next;
   int    m_score = 0, m_lives = 3, m_level = 1, m_cnt = 0, m_high = 0;

   logic [4:0] r_hp;
   logic       r_amd, r_sof, r_mk;
   logic [8:0] r_key;

   always #5 clk = ~clk;

   game_controller dut (
      .clk               (clk),
      .rst               (rst),
      .startOfFrame      (startOfFrame),
      .keyCode           (keyCode),
      .make              (make),
      .HitPulse          (HitPulse),
      .all_monsters_dead (all_monsters_dead),
      .level_reset       (level_reset),
      .freeze            (freeze),
      .game_active       (game_active),
      .game_over         (game_over),
      .score_bcd         (score_bcd),
      .lives             (lives),
`ifdef HIGH_SCORE_EN
      .high_score_bcd    (high_score_bcd),
`endif
      .level             (level)
   );

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: actual=%0h expected=%0h", name, $time, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [4:0] hp, input logic amd, input logic sof,
                                input logic mk, input logic [8:0] key);
      HitPulse          = hp;
      all_monsters_dead = amd;
      startOfFrame      = sof;
      make              = mk;
      keyCode           = key;
      @(posedge clk);
      #1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(5'b0, 1'b0, 1'b1, 1'b0, 9'h0);
         applyStimulus(5'b0, 1'b0, 1'b0, 1'b0, 9'h0);
      end
   endtask

   // Game rules in decimal arithmetic with named states; pause counters count up to the frame total.
   always @(posedge clk) begin
      if (rst) begin
         m_state = "IDLE";
         m_score = 0;
         m_lives = 3;
         m_level = 1;
         m_cnt   = 0;
         m_high  = 0;
      end else begin
         m_next = m_state;
         if (startOfFrame) m_cnt++;
         case (m_state)
            "IDLE": if (make && keyCode == START_KEY) begin
               m_next  = "PLAY";
               m_score = 0;
               m_lives = 3;
               m_level = 1;
            end
            "PLAY": begin
               m_score = m_score + HitPulse[0] + HitPulse[4];
               if (m_score > 9999) m_score = 9999;
               if (HitPulse[2]) m_next = "GAME_OVER";
               else if (HitPulse[1]) begin
                  m_lives = m_lives - 1;
                  m_next  = (m_lives == 0) ? "GAME_OVER" : "DYING";
               end else if (all_monsters_dead) begin
                  m_level = (m_level < 9) ? m_level + 1 : 9;
                  m_next  = "LEVEL_DONE";
               end
            end
            "DYING":      if (m_cnt == 90) m_next = "PLAY";
            "LEVEL_DONE": if (m_cnt == 60) m_next = "PLAY";
            "GAME_OVER":  if (make && keyCode == START_KEY) m_next = "IDLE";
            default:      m_next = "IDLE";
         endcase
         if (m_next != m_state) begin
            m_cnt = 0;
            if (m_next == "GAME_OVER" && m_score > m_high) m_high = m_score;
         end
         m_state = m_next;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("score", 32'(score_bcd), 32'(to_bcd(m_score)));
         checkOutput("lives", 32'(lives), 32'(m_lives));
         checkOutput("level", 32'(level), 32'(m_level));
         checkOutput("level_reset", 32'(level_reset),
                     32'(m_state == "IDLE" || m_state == "LEVEL_DONE"));
         checkOutput("freeze", 32'(freeze), 32'(m_state != "PLAY"));
         checkOutput("game_active", 32'(game_active), 32'(m_state == "PLAY"));
         checkOutput("game_over", 32'(game_over), 32'(m_state == "GAME_OVER"));
`ifdef HIGH_SCORE_EN
         checkOutput("high_score", 32'(high_score_bcd), 32'(to_bcd(m_high)));
`endif
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_en = 1'b1;
      checkOutput("rst_lives", 32'(lives), 32'd3);
      checkOutput("rst_level", 32'(level), 32'd1);
      checkOutput("rst_score", 32'(score_bcd), 32'h0);
      checkOutput("rst_level_reset", 32'(level_reset), 32'd1);
      checkOutput("rst_freeze", 32'(freeze), 32'd1);
      rst = 1'b0;

      applyStimulus(5'b0, 1'b0, 1'b0, 1'b1, 9'h01C);
      checkOutput("wrong_key_idle", 32'(game_active), 32'd0);
      applyStimulus(5'b0, 1'b0, 1'b0, 1'b1, START_KEY);
      checkOutput("start_play", 32'(game_active), 32'd1);
      checkOutput("start_freeze", 32'(freeze), 32'd0);

      repeat (12) applyStimulus(5'b00001, 1'b0, 1'b0, 1'b0, 9'h0);
      checkOutput("score_12", 32'(score_bcd), 32'h0012);
      applyStimulus(5'b10001, 1'b0, 1'b0, 1'b0, 9'h0);
      checkOutput("score_plus2", 32'(score_bcd), 32'h0014);
      applyStimulus(5'b01000, 1'b0, 1'b0, 1'b0, 9'h0);
      checkOutput("border_ignored", 32'(score_bcd), 32'h0014);

      applyStimulus(5'b00011, 1'b0, 1'b0, 1'b0, 9'h0);
      checkOutput("death_lives", 32'(lives), 32'd2);
      checkOutput("death_score", 32'(score_bcd), 32'h0015);
      applyStimulus(5'b00001, 1'b0, 1'b0, 1'b0, 9'h0);
      checkOutput("dying_drop", 32'(score_bcd), 32'h0015);
      frames(89);
      checkOutput("dying_89", 32'(game_active), 32'd0);
      frames(1);
      checkOutput("dying_90", 32'(freeze), 32'd0);

      applyStimulus(5'b0, 1'b1, 1'b0, 1'b0, 9'h0);
      checkOutput("lvl_level", 32'(level), 32'd2);
      checkOutput("lvl_reset", 32'(level_reset), 32'd1);
      frames(59);
      checkOutput("lvl_59", 32'(level_reset), 32'd1);
      frames(1);
      checkOutput("lvl_60", 32'(game_active), 32'd1);

      applyStimulus(5'b00010, 1'b0, 1'b0, 1'b0, 9'h0);
      frames(90);
      applyStimulus(5'b00010, 1'b1, 1'b0, 1'b0, 9'h0);
      checkOutput("last_life_over", 32'(game_over), 32'd1);
      checkOutput("last_life_lives", 32'(lives), 32'd0);
      checkOutput("last_life_level", 32'(level), 32'd2);

      applyStimulus(5'b00001, 1'b0, 1'b0, 1'b0, 9'h0);
      applyStimulus(5'b0, 1'b0, 1'b0, 1'b1, START_KEY);
      applyStimulus(5'b0, 1'b0, 1'b0, 1'b1, START_KEY);
      checkOutput("restart_score", 32'(score_bcd), 32'h0);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(5'b0, 1'b1, 1'b0, 1'b0, 9'h0);
         frames(60);
      end
      checkOutput("level_sat", 32'(level), 32'd9);

      repeat (4999) applyStimulus(5'b10001, 1'b0, 1'b0, 1'b0, 9'h0);
      checkOutput("score_9998", 32'(score_bcd), 32'h9998);
      applyStimulus(5'b10001, 1'b0, 1'b0, 1'b0, 9'h0);
      checkOutput("score_sat", 32'(score_bcd), 32'h9999);
      applyStimulus(5'b00001, 1'b0, 1'b0, 1'b0, 9'h0);
      applyStimulus(5'b00100, 1'b0, 1'b0, 1'b0, 9'h0);
      checkOutput("endzone_over", 32'(game_over), 32'd1);
`ifdef HIGH_SCORE_EN
      checkOutput("high_9999", 32'(high_score_bcd), 32'h9999);
`endif

      applyStimulus(5'b0, 1'b0, 1'b0, 1'b1, START_KEY);
      applyStimulus(5'b0, 1'b0, 1'b0, 1'b1, START_KEY);
      repeat (5) applyStimulus(5'b00001, 1'b0, 1'b0, 1'b0, 9'h0);
      rst = 1'b1;
      applyStimulus(5'b00001, 1'b0, 1'b0, 1'b0, 9'h0);
      rst = 1'b0;
      checkOutput("midgame_rst_score", 32'(score_bcd), 32'h0);
      checkOutput("midgame_rst_reset", 32'(level_reset), 32'd1);

      for (int i = 0; i < 15000; i++) begin
         r_hp[0] = ($urandom_range(3) == 0);
         r_hp[1] = ($urandom_range(39) == 0);
         r_hp[2] = ($urandom_range(299) == 0);
         r_hp[3] = ($urandom_range(3) == 0);
         r_hp[4] = ($urandom_range(7) == 0);
         r_amd   = ($urandom_range(59) == 0);
         r_sof   = ($urandom_range(3) == 0);
         r_mk    = ($urandom_range(7) == 0);
         r_key   = ($urandom_range(1) == 0) ? START_KEY : 9'($urandom);
         rst     = ($urandom_range(2999) == 0);
         applyStimulus(r_hp, r_amd, r_sof, r_mk, r_key);
      end
      rst = 1'b0;
      applyStimulus(5'b0, 1'b0, 1'b0, 1'b0, 9'h0);
      @(negedge clk);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
